// File: rtl/delta_tile_sequencer.sv
// Delta accelerator tile sequencer.
// Walks a convolution layer tile by tile (input-channel tiles innermost, then
// output columns, output rows, output-channel groups outermost). It pulses the
// sub-loader and PU-array starts, drives the DRAM port select and presents the
// active extent of the current tile. Partial edge tiles are computed.
//
// state  | meaning
// IDLE   | waiting for start
// ACK    | start acknowledged, layer parameters latched
// INS    | launch input DRAM->SRAM load
// INS_W  | wait for in_sram_done
// CHK    | decide: finish layer, or load bias / fill input buffer
// BIAS   | launch bias load (first input-channel tile only)
// BIAS_W | wait for bias_done
// IB     | launch input buffer fill
// IB_W   | wait for ib_done
// OP     | launch PU array and weight streaming
// OP_W   | wait for every active PU to finish
// OP_FIN | close the weight stream
// OB     | launch output-buffer drain (last input-channel tile only)
// OB_W   | wait for ob_done
// ADV    | advance tile indices
// OS     | launch output SRAM->DRAM store
// OS_W   | wait for os_done
// DONE   | layer finished
module delta_tile_sequencer #(
    parameter int PU_NUM  = 4,
    parameter int PU_OC   = 8,
    parameter int TILE_IC = 8,
    parameter int TILE_OH = 8,
    parameter int TILE_OW = 8,
    parameter int MAX_IC  = 1024,
    parameter int MAX_OC  = 1024,
    parameter int MAX_FS  = 256,
    localparam int CW   = $clog2(MAX_IC + 1),
    localparam int OW   = $clog2(MAX_OC + 1),
    localparam int FW   = $clog2(MAX_FS + 1),
    localparam int PICW = $clog2(TILE_IC + 1),
    localparam int TRW  = $clog2(TILE_OH + 1),
    localparam int TCW  = $clog2(TILE_OW + 1),
    localparam int POCW = $clog2(PU_OC + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    output logic                     ack,
    output logic                     done,
    output logic                     busy,
    input  logic [CW-1:0]            ic_num,
    input  logic [OW-1:0]            oc_num,
    input  logic [FW-1:0]            orc_size,
    input  logic                     load_input,
    input  logic                     store_output,
    output logic                     in_sram_start,
    input  logic                     in_sram_done,
    output logic                     bias_start,
    input  logic                     bias_done,
    output logic                     ib_start,
    input  logic                     ib_done,
    output logic                     pu_start,
    output logic                     wgt_start,
    input  logic [PU_NUM-1:0]        pu_finished,
    output logic                     wgt_finish,
    output logic                     ob_start,
    input  logic                     ob_done,
    output logic                     os_start,
    input  logic                     os_done,
    output logic [2:0]               dram_sel,
    output logic [CW-1:0]            i_ch,
    output logic [OW-1:0]            o_ch,
    output logic [FW-1:0]            o_r,
    output logic [FW-1:0]            o_c,
    output logic [PICW-1:0]          pu_ic_num,
    output logic [TRW-1:0]           tile_rows,
    output logic [TCW-1:0]           tile_cols,
    output logic [PU_NUM*POCW-1:0]   pu_oc_num
);

    localparam int G = PU_NUM * PU_OC;

    typedef enum logic [4:0] {
        S_IDLE, S_ACK, S_INS, S_INS_W, S_CHK, S_BIAS, S_BIAS_W, S_IB, S_IB_W,
        S_OP, S_OP_W, S_OP_FIN, S_OB, S_OB_W, S_ADV, S_OS, S_OS_W, S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CW-1:0] r_ic_num;
    logic [OW-1:0] r_oc_num;
    logic [FW-1:0] r_orc;
    logic          r_load_in;
    logic          r_store_out;
    logic [CW-1:0] r_i_ch;
    logic [OW-1:0] r_o_ch;
    logic [FW-1:0] r_o_r;
    logic [FW-1:0] r_o_c;
    logic          r_complete;

    logic [CW:0]   w_ic_sum;
    logic [OW:0]   w_och_sum;
    logic [FW:0]   w_or_sum;
    logic [FW:0]   w_col_sum;
    logic          w_last_ic;
    logic          w_zero_dim;
    logic [PU_NUM-1:0] w_active;
    logic          w_pu_all_done;

    logic signed [CW+1:0] w_ic_rem;
    logic signed [FW+1:0] w_row_rem;
    logic signed [FW+1:0] w_col_rem;

    assign w_ic_sum   = {1'b0, r_i_ch} + (CW+1)'(TILE_IC);
    assign w_och_sum  = {1'b0, r_o_ch} + (OW+1)'(G);
    assign w_or_sum   = {1'b0, r_o_r}  + (FW+1)'(TILE_OH);
    assign w_col_sum  = {1'b0, r_o_c}  + (FW+1)'(TILE_OW);
    assign w_last_ic  = (w_ic_sum >= {1'b0, r_ic_num});
    assign w_zero_dim = (r_ic_num == '0) || (r_oc_num == '0) || (r_orc == '0);

    // Remaining extent of the current tile; clamped to [0, tile size].
    assign w_ic_rem  = $signed({2'b00, r_ic_num}) - $signed({2'b00, r_i_ch});
    assign w_row_rem = $signed({2'b00, r_orc}) - $signed({2'b00, r_o_r});
    assign w_col_rem = $signed({2'b00, r_orc}) - $signed({2'b00, r_o_c});

    assign pu_ic_num = (w_ic_rem[CW+1] || w_ic_rem == '0) ? '0 :
                       (w_ic_rem >= (CW+2)'(TILE_IC)) ? PICW'(TILE_IC) : w_ic_rem[PICW-1:0];
    assign tile_rows = (w_row_rem[FW+1] || w_row_rem == '0) ? '0 :
                       (w_row_rem >= (FW+2)'(TILE_OH)) ? TRW'(TILE_OH) : w_row_rem[TRW-1:0];
    assign tile_cols = (w_col_rem[FW+1] || w_col_rem == '0) ? '0 :
                       (w_col_rem >= (FW+2)'(TILE_OW)) ? TCW'(TILE_OW) : w_col_rem[TCW-1:0];

    for (genvar p = 0; p < PU_NUM; p++) begin : g_pu_oc
        logic signed [OW+1:0] w_oc_rem;
        assign w_oc_rem = $signed({2'b00, r_oc_num}) - $signed({2'b00, r_o_ch})
                          - (OW+2)'(p * PU_OC);
        assign pu_oc_num[p*POCW +: POCW] =
            (w_oc_rem[OW+1] || w_oc_rem == '0) ? '0 :
            (w_oc_rem >= (OW+2)'(PU_OC)) ? POCW'(PU_OC) : w_oc_rem[POCW-1:0];
        assign w_active[p] = (pu_oc_num[p*POCW +: POCW] != '0);
    end

    // PUs with no output channels in this tile never report and are masked out.
    assign w_pu_all_done = &(pu_finished | ~w_active);

    assign i_ch = r_i_ch;
    assign o_ch = r_o_ch;
    assign o_r  = r_o_r;
    assign o_c  = r_o_c;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Layer parameters are captured at start; indices step as an odometer on ADV exit.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ic_num    <= '0;
            r_oc_num    <= '0;
            r_orc       <= '0;
            r_load_in   <= 1'b0;
            r_store_out <= 1'b0;
            r_i_ch      <= '0;
            r_o_ch      <= '0;
            r_o_r       <= '0;
            r_o_c       <= '0;
            r_complete  <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            r_ic_num    <= ic_num;
            r_oc_num    <= oc_num;
            r_orc       <= orc_size;
            r_load_in   <= load_input;
            r_store_out <= store_output;
            r_i_ch      <= '0;
            r_o_ch      <= '0;
            r_o_r       <= '0;
            r_o_c       <= '0;
            r_complete  <= 1'b0;
        end else if (r_state == S_ADV && !abort) begin
            if (w_last_ic) begin
                r_i_ch <= '0;
                if (w_col_sum >= {1'b0, r_orc}) begin
                    r_o_c <= '0;
                    if (w_or_sum >= {1'b0, r_orc}) begin
                        r_o_r  <= '0;
                        r_o_ch <= w_och_sum[OW-1:0];
                        if (w_och_sum >= {1'b0, r_oc_num}) r_complete <= 1'b1;
                    end else begin
                        r_o_r <= w_or_sum[FW-1:0];
                    end
                end else begin
                    r_o_c <= w_col_sum[FW-1:0];
                end
            end else begin
                r_i_ch <= w_ic_sum[CW-1:0];
            end
        end
    end

    // Next-state and state-decoded outputs; abort overrides every transition.
    always_comb begin
        w_state_nxt   = r_state;
        ack           = 1'b0;
        done          = 1'b0;
        busy          = (r_state != S_IDLE);
        in_sram_start = 1'b0;
        bias_start    = 1'b0;
        ib_start      = 1'b0;
        pu_start      = 1'b0;
        wgt_start     = 1'b0;
        wgt_finish    = 1'b0;
        ob_start      = 1'b0;
        os_start      = 1'b0;
        dram_sel      = 3'd0;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_ACK;
            S_ACK: begin
                ack         = 1'b1;
                w_state_nxt = r_load_in ? S_INS : S_CHK;
            end
            S_INS: begin
                in_sram_start = 1'b1;
                dram_sel      = 3'd1;
                w_state_nxt   = S_INS_W;
            end
            S_INS_W: begin
                dram_sel = 3'd1;
                if (in_sram_done) w_state_nxt = S_CHK;
            end
            S_CHK: begin
                if (r_complete || w_zero_dim) w_state_nxt = r_store_out ? S_OS : S_DONE;
                else if (r_i_ch == '0)        w_state_nxt = S_BIAS;
                else                          w_state_nxt = S_IB;
            end
            S_BIAS: begin
                bias_start  = 1'b1;
                dram_sel    = 3'd3;
                w_state_nxt = S_BIAS_W;
            end
            S_BIAS_W: begin
                dram_sel = 3'd3;
                if (bias_done) w_state_nxt = S_IB;
            end
            S_IB: begin
                ib_start    = 1'b1;
                dram_sel    = 3'd1;
                w_state_nxt = S_IB_W;
            end
            S_IB_W: begin
                dram_sel = 3'd1;
                if (ib_done) w_state_nxt = S_OP;
            end
            S_OP: begin
                pu_start    = 1'b1;
                wgt_start   = 1'b1;
                dram_sel    = 3'd4;
                w_state_nxt = S_OP_W;
            end
            S_OP_W: begin
                dram_sel = 3'd4;
                if (w_pu_all_done) w_state_nxt = S_OP_FIN;
            end
            S_OP_FIN: begin
                wgt_finish  = 1'b1;
                dram_sel    = 3'd4;
                w_state_nxt = w_last_ic ? S_OB : S_ADV;
            end
            S_OB: begin
                ob_start    = 1'b1;
                dram_sel    = 3'd2;
                w_state_nxt = S_OB_W;
            end
            S_OB_W: begin
                dram_sel = 3'd2;
                if (ob_done) w_state_nxt = S_ADV;
            end
            S_ADV:    w_state_nxt = S_CHK;
            S_OS: begin
                os_start    = 1'b1;
                dram_sel    = 3'd2;
                w_state_nxt = S_OS_W;
            end
            S_OS_W: begin
                dram_sel = 3'd2;
                if (os_done) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default:  w_state_nxt = S_IDLE;
        endcase
        if (abort && r_state != S_IDLE) w_state_nxt = S_IDLE;
    end

endmodule

// File: tb/tb_delta_tile_sequencer.sv
// Randomised bench for delta_tile_sequencer: a responder answers every start
// with a delayed done, and each compute launch is compared against a tile list
// produced by plain nested loops over the layer.
module tb_delta_tile_sequencer;

    localparam int PU_NUM  = 4;
    localparam int PU_OC   = 8;
    localparam int TILE_IC = 8;
    localparam int TILE_OH = 8;
    localparam int TILE_OW = 8;
    localparam int G    = PU_NUM * PU_OC;
    localparam int CW   = $clog2(1024 + 1);
    localparam int OW   = $clog2(1024 + 1);
    localparam int FW   = $clog2(256 + 1);
    localparam int PICW = $clog2(TILE_IC + 1);
    localparam int TRW  = $clog2(TILE_OH + 1);
    localparam int TCW  = $clog2(TILE_OW + 1);
    localparam int POCW = $clog2(PU_OC + 1);

    logic clock, reset, start, abort, ack, done, busy;
    logic [CW-1:0] ic_num;
    logic [OW-1:0] oc_num;
    logic [FW-1:0] orc_size;
    logic load_input, store_output;
    logic in_sram_start, in_sram_done, bias_start, bias_done, ib_start, ib_done;
    logic pu_start, wgt_start, wgt_finish, ob_start, ob_done, os_start, os_done;
    logic [PU_NUM-1:0] pu_finished;
    logic [2:0] dram_sel;
    logic [CW-1:0] i_ch;
    logic [OW-1:0] o_ch;
    logic [FW-1:0] o_r, o_c;
    logic [PICW-1:0] pu_ic_num;
    logic [TRW-1:0] tile_rows;
    logic [TCW-1:0] tile_cols;
    logic [PU_NUM*POCW-1:0] pu_oc_num;

    delta_tile_sequencer dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .ack(ack), .done(done), .busy(busy),
        .ic_num(ic_num), .oc_num(oc_num), .orc_size(orc_size),
        .load_input(load_input), .store_output(store_output),
        .in_sram_start(in_sram_start), .in_sram_done(in_sram_done),
        .bias_start(bias_start), .bias_done(bias_done),
        .ib_start(ib_start), .ib_done(ib_done),
        .pu_start(pu_start), .wgt_start(wgt_start), .pu_finished(pu_finished),
        .wgt_finish(wgt_finish), .ob_start(ob_start), .ob_done(ob_done),
        .os_start(os_start), .os_done(os_done), .dram_sel(dram_sel),
        .i_ch(i_ch), .o_ch(o_ch), .o_r(o_r), .o_c(o_c),
        .pu_ic_num(pu_ic_num), .tile_rows(tile_rows), .tile_cols(tile_cols),
        .pu_oc_num(pu_oc_num)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    typedef struct {
        int i_ch, o_ch, o_r, o_c, pic, rows, cols;
        logic [PU_NUM*POCW-1:0] poc;
    } tile_t;

    tile_t exp_q[$];

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Reference: enumerate every tile of the layer in walk order.
    task automatic build_model(input int ic, input int oc, input int orc,
                               output int n_bias, output int n_ob);
        tile_t t;
        n_bias = 0;
        n_ob   = 0;
        exp_q.delete();
        if (ic == 0 || oc == 0 || orc == 0) return;
        for (int og = 0; og < oc; og += G)
            for (int r = 0; r < orc; r += TILE_OH)
                for (int c = 0; c < orc; c += TILE_OW)
                    for (int i = 0; i < ic; i += TILE_IC) begin
                        t.i_ch = i; t.o_ch = og; t.o_r = r; t.o_c = c;
                        t.pic  = imin(TILE_IC, ic - i);
                        t.rows = imin(TILE_OH, orc - r);
                        t.cols = imin(TILE_OW, orc - c);
                        for (int p = 0; p < PU_NUM; p++) begin
                            int rem;
                            rem = oc - og - p * PU_OC;
                            if (rem < 0) rem = 0;
                            if (rem > PU_OC) rem = PU_OC;
                            t.poc[p*POCW +: POCW] = POCW'(rem);
                        end
                        if (i == 0) n_bias++;
                        if (i + TILE_IC >= ic) n_ob++;
                        exp_q.push_back(t);
                    end
    endtask

    task automatic clear_inputs();
        in_sram_done = 0; bias_done = 0; ib_done = 0; ob_done = 0; os_done = 0;
        pu_finished = '0; start = 0; abort = 0;
    endtask

    // Runs one layer with a randomised responder; abort_tile > 0 aborts in
    // OP_W of that compute tile. done_cyc returns the cycle done was seen.
    task automatic run_layer(input string nm, input int ic, input int oc, input int orc,
                             input bit li, input bit so, input bit tie3,
                             input int abort_tile, output int done_cyc);
        int n_bias_e, n_ob_e, n_tiles_e;
        int c_ins, c_bias, c_ib, c_pu, c_ob, c_os, c_done, c_ack, c_wf;
        int cd_ins, cd_bias, cd_ib, cd_ob, cd_os, cyc;
        int cd_pu[PU_NUM];
        bit fin, aborted, abort_pend;
        tile_t t;
        build_model(ic, oc, orc, n_bias_e, n_ob_e);
        n_tiles_e = exp_q.size();
        c_ins = 0; c_bias = 0; c_ib = 0; c_pu = 0; c_ob = 0; c_os = 0;
        c_done = 0; c_ack = 0; c_wf = 0;
        cd_ins = 0; cd_bias = 0; cd_ib = 0; cd_ob = 0; cd_os = 0; cyc = 0;
        for (int p = 0; p < PU_NUM; p++) cd_pu[p] = 0;
        fin = 0; aborted = 0; abort_pend = 0; done_cyc = -1;

        @(negedge clock);
        ic_num = CW'(ic); oc_num = OW'(oc); orc_size = FW'(orc);
        load_input = li; store_output = so; start = 1;
        @(negedge clock);
        start = 0;
        check_val({nm, " ack"}, ack, 1);
        check_val({nm, " busy"}, busy, 1);
        ic_num = CW'($urandom); oc_num = OW'($urandom); orc_size = FW'($urandom);

        while (!fin && cyc < 20000) begin
            @(negedge clock);
            cyc++;
            start = 0;
            if (abort) begin
                check_val({nm, " abort busy"}, busy, 0);
                check_val({nm, " abort done"}, done, 0);
                abort = 0;
                aborted = 1;
                fin = 1;
            end else begin
                if (abort_pend) begin abort = 1; abort_pend = 0; end
                in_sram_done = 0; bias_done = 0; ib_done = 0; ob_done = 0; os_done = 0;
                if (cd_ins  > 0) begin cd_ins--;  if (cd_ins  == 0) in_sram_done = 1; end
                if (cd_bias > 0) begin cd_bias--; if (cd_bias == 0) bias_done = 1; end
                if (cd_ib   > 0) begin cd_ib--;   if (cd_ib   == 0) ib_done = 1; end
                if (cd_ob   > 0) begin cd_ob--;   if (cd_ob   == 0) ob_done = 1; end
                if (cd_os   > 0) begin cd_os--;   if (cd_os   == 0) os_done = 1; end
                for (int p = 0; p < PU_NUM; p++)
                    if (cd_pu[p] > 0) begin
                        cd_pu[p]--;
                        if (cd_pu[p] == 0 && !(tie3 && p == 3)) pu_finished[p] = 1;
                    end
                if (ack) c_ack++;
                if (wgt_finish) c_wf++;
                if (in_sram_start) begin
                    c_ins++; check_val({nm, " sel ins"}, dram_sel, 1);
                    cd_ins = $urandom_range(1, 3);
                end
                if (bias_start) begin
                    c_bias++; check_val({nm, " sel bias"}, dram_sel, 3);
                    cd_bias = $urandom_range(1, 3);
                end
                if (ib_start) begin
                    c_ib++; check_val({nm, " sel ib"}, dram_sel, 1);
                    cd_ib = $urandom_range(1, 3);
                end
                if (ob_start) begin
                    c_ob++; check_val({nm, " sel ob"}, dram_sel, 2);
                    cd_ob = $urandom_range(1, 3);
                end
                if (os_start) begin
                    c_os++; check_val({nm, " sel os"}, dram_sel, 2);
                    cd_os = $urandom_range(1, 3);
                end
                if (pu_start) begin
                    c_pu++;
                    check_val({nm, " wgt_start"}, wgt_start, 1);
                    check_val({nm, " sel op"}, dram_sel, 4);
                    pu_finished = '0;
                    if (exp_q.size() > 0) begin
                        t = exp_q.pop_front();
                        check_val({nm, " i_ch"}, i_ch, t.i_ch);
                        check_val({nm, " o_ch"}, o_ch, t.o_ch);
                        check_val({nm, " o_r"}, o_r, t.o_r);
                        check_val({nm, " o_c"}, o_c, t.o_c);
                        check_val({nm, " pu_ic_num"}, pu_ic_num, t.pic);
                        check_val({nm, " tile_rows"}, tile_rows, t.rows);
                        check_val({nm, " tile_cols"}, tile_cols, t.cols);
                        check_val({nm, " pu_oc_num"}, pu_oc_num, t.poc);
                        for (int p = 0; p < PU_NUM; p++)
                            cd_pu[p] = (t.poc[p*POCW +: POCW] != '0) ? $urandom_range(1, 4) : 0;
                    end else begin
                        check_val({nm, " extra tile"}, c_pu, n_tiles_e);
                    end
                    if (c_pu == abort_tile) abort_pend = 1;
                end
                if (done) begin c_done++; fin = 1; done_cyc = cyc; end
                if (!fin && cyc == 5) start = 1;
            end
        end
        if (!fin) check_val({nm, " timeout"}, cyc, 0);
        clear_inputs();
        if (!aborted) begin
            @(negedge clock);
            check_val({nm, " busy after done"}, busy, 0);
            check_val({nm, " done single"}, done, 0);
            check_val({nm, " tiles"}, c_pu, n_tiles_e);
            check_val({nm, " ib loads"}, c_ib, n_tiles_e);
            check_val({nm, " wgt_finish"}, c_wf, n_tiles_e);
            check_val({nm, " bias loads"}, c_bias, n_bias_e);
            check_val({nm, " ob drains"}, c_ob, n_ob_e);
            check_val({nm, " ins loads"}, c_ins, li ? 1 : 0);
            check_val({nm, " os stores"}, c_os, so ? 1 : 0);
            check_val({nm, " done count"}, c_done, 1);
            check_val({nm, " extra ack"}, c_ack, 0);
        end else begin
            check_val({nm, " no done on abort"}, c_done, 0);
        end
    endtask

    int dc;
    int wait_cyc;

    initial begin
        reset = 1; ic_num = '0; oc_num = '0; orc_size = '0;
        load_input = 0; store_output = 0;
        clear_inputs();
        repeat (3) @(negedge clock);
        check_val("rst busy", busy, 0);
        check_val("rst ack", ack, 0);
        check_val("rst done", done, 0);
        check_val("rst dram_sel", dram_sel, 0);
        check_val("rst idx", {i_ch, o_ch, o_r, o_c}, 0);
        check_val("rst counts", {pu_ic_num, tile_rows, tile_cols, pu_oc_num}, 0);
        check_val("rst starts", {in_sram_start, bias_start, ib_start, pu_start,
                                 wgt_start, wgt_finish, ob_start, os_start}, 0);
        reset = 0;

        run_layer("t1", 16, 32, 8, 1, 1, 0, -1, dc);
        run_layer("t2", 12, 20, 12, 0, 1, 0, -1, dc);
        run_layer("t3", 12, 20, 8, 0, 0, 1, -1, dc);
        run_layer("t4abort", 16, 64, 16, 1, 1, 0, 3, dc);
        run_layer("t4rerun", 16, 64, 16, 0, 1, 0, -1, dc);
        run_layer("t5zero", 0, 32, 8, 0, 0, 0, -1, dc);
        check_val("t5 done latency", dc, 2);

        // Reset in the middle of IB_W.
        @(negedge clock);
        ic_num = 16; oc_num = 32; orc_size = 8; load_input = 0; store_output = 0;
        start = 1; bias_done = 1;
        wait_cyc = 0;
        @(negedge clock);
        start = 0;
        while (!ib_start && wait_cyc < 50) begin @(negedge clock); wait_cyc++; end
        if (!ib_start) check_val("t6 ib timeout", wait_cyc, 0);
        @(negedge clock);
        reset = 1;
        @(negedge clock);
        reset = 0; bias_done = 0;
        check_val("t6 busy", busy, 0);
        check_val("t6 dram_sel", dram_sel, 0);
        check_val("t6 idx", {i_ch, o_ch, o_r, o_c}, 0);
        check_val("t6 counts", {pu_ic_num, tile_rows, tile_cols, pu_oc_num}, 0);
        in_sram_done = 1;
        @(negedge clock);
        in_sram_done = 0;
        @(negedge clock);
        check_val("t6 idle ignore", {busy, ack, in_sram_start, done}, 0);
        run_layer("t6after", 20, 40, 10, 1, 0, 0, -1, dc);

        for (int k = 0; k < 6; k++) begin
            run_layer("rnd", $urandom_range(1, 40), $urandom_range(1, 70),
                      $urandom_range(1, 20), 1'($urandom), 1'($urandom), 0, -1, dc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
